i2c_master_sequencer: RTL and testbench

Transaction-level controller for the I2C master. It sequences one complete bus transaction: bus-free check, START, address byte, N data bytes (TX or RX), and STOP. It drives the byte-level bit timer (`timer_active`, `direction`, `should_nack`) and reacts to its `byte_complete`, `ack` and `abort` outputs. It sits between the APB register/FIFO layer and the timer plus shift-register datapath, and selects who drives SCL and SDA during each phase.

---
 rtl/i2c_master_sequencer_pkg.sv | 23 ++
 rtl/i2c_master_sequencer_if.sv | 47 ++++
 rtl/i2c_master_sequencer_flex_counter.sv | 25 ++
 rtl/i2c_master_sequencer.sv | 170 +++++++++++++++++
 tb/tb_i2c_master_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_master_sequencer_pkg.sv
// Shared types for the I2C master transaction sequencer: line-source select,
// byte direction and the half-period helper.
package i2c_master_sequencer_pkg;

  typedef enum logic [1:0] {
    RELEASE = 2'd0,
    LOW     = 2'd1,
    TIMER   = 2'd2
  } LineSel;

  typedef enum logic {
    TX = 1'b0,
    RX = 1'b1
  } DataDirection;

  localparam int CNT_W = 32;

  // A zero divider would never roll over; run it as a one-cycle half period.
  function automatic logic [CNT_W-1:0] half_period(input logic [CNT_W-1:0] div);
    return (div == '0) ? CNT_W'(1) : div;
  endfunction

endpackage

// File: rtl/i2c_master_sequencer_if.sv
// Host, bus-level and bit-timer signals seen by the transaction sequencer.
interface i2c_master_sequencer_if;
  import i2c_master_sequencer_pkg::*;

  logic [31:0]  clock_div;
  logic         start_txn;
  logic [6:0]   slave_addr;
  logic         rw;
  logic [5:0]   byte_count;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [7:0]   rx_byte;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         SDA_sync;
  logic         SCL_sync;
  logic         timer_active;
  DataDirection direction;
  logic         should_nack;
  logic         byte_complete;
  logic         ack;
  logic         abort;
  logic         load_shift;
  logic [7:0]   load_byte;
  LineSel       scl_sel;
  LineSel       sda_sel;
  logic         busy;
  logic         done;
  logic         nack_err;
  logic         arb_lost;

  modport master (
    input  clock_div, start_txn, slave_addr, rw, byte_count, tx_data, tx_valid,
           rx_byte, SDA_sync, SCL_sync, byte_complete, ack, abort,
    output tx_ready, rx_data, rx_valid, timer_active, direction, should_nack,
           load_shift, load_byte, scl_sel, sda_sel, busy, done, nack_err, arb_lost
  );

  modport slave (
    output clock_div, start_txn, slave_addr, rw, byte_count, tx_data, tx_valid,
           rx_byte, SDA_sync, SCL_sync, byte_complete, ack, abort,
    input  tx_ready, rx_data, rx_valid, timer_active, direction, should_nack,
           load_shift, load_byte, scl_sel, sda_sel, busy, done, nack_err, arb_lost
  );

endinterface

// File: rtl/i2c_master_sequencer_flex_counter.sv
// Clearable up-counter that wraps to zero and flags the cycle it reaches
// rollover_val-1, giving a rollover_val-cycle period.
module flex_counter #(
  parameter int NUM_CNT_BITS = 32
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_out;

  assign rollover_flag = count_enable && (count_out == rollover_val - NUM_CNT_BITS'(1));

  always_ff @(posedge clk, negedge n_rst) begin
    if (!n_rst)             count_out <= '0;
    else if (clear)         count_out <= '0;
    else if (rollover_flag) count_out <= '0;
    else if (count_enable)  count_out <= count_out + NUM_CNT_BITS'(1);
  end

endmodule

// File: rtl/i2c_master_sequencer.sv
// I2C master transaction sequencer: bus-free wait, START, address, N data
// bytes (TX or RX), STOP; steers the bit timer and the SCL/SDA sources.
module i2c_master_sequencer #(
  parameter int MAX_BYTES = 32
) (
  input  logic                          clk,
  input  logic                          n_rst,
  i2c_master_sequencer_if.master        bus
);
  import i2c_master_sequencer_pkg::*;

  localparam int RW = $clog2(MAX_BYTES + 1);

  typedef enum logic [3:0] {
    IDLE, BUS_WAIT, START_HOLD, LOAD_ADDR, ADDR_XFER, LOAD_DATA, TX_XFER,
    RX_XFER, RX_PUSH, GAP, STOP_LOW, STOP_SETUP, STOP_HOLD, DONE
  } state_t;

  state_t        state;
  logic [6:0]    addr;
  logic          rd;
  logic [RW-1:0] remaining;
  logic          cnt_en;
  logic          tick;
  logic          in_xfer;

  assign in_xfer = (state == ADDR_XFER) || (state == TX_XFER) || (state == RX_XFER);

  // The counter is held at zero whenever it is not counting and wraps on
  // rollover, so each timed state starts from a fresh half period.
  always_comb begin
    cnt_en = 1'b0;
    case (state)
      BUS_WAIT:                      cnt_en = bus.SCL_sync && bus.SDA_sync;
      START_HOLD, STOP_LOW, STOP_HOLD: cnt_en = 1'b1;
      STOP_SETUP:                    cnt_en = bus.SCL_sync;
      default:                       cnt_en = 1'b0;
    endcase
  end

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_half (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (!cnt_en),
    .count_enable (cnt_en),
    .rollover_val (half_period(bus.clock_div)),
    .rollover_flag(tick)
  );

  // Line selects and timer controls decode straight from state, so a reset
  // releases both lines without waiting for a clock.
  always_comb begin
    bus.scl_sel      = RELEASE;
    bus.sda_sel      = RELEASE;
    bus.timer_active = 1'b0;
    bus.direction    = TX;
    bus.should_nack  = 1'b0;
    bus.load_shift   = 1'b0;
    bus.load_byte    = {addr, rd};
    bus.tx_ready     = 1'b0;
    case (state)
      START_HOLD: bus.sda_sel = LOW;
      LOAD_ADDR: begin
        bus.sda_sel    = LOW;
        bus.load_shift = 1'b1;
      end
      ADDR_XFER, TX_XFER: begin
        bus.timer_active = 1'b1;
        bus.scl_sel      = TIMER;
        bus.sda_sel      = TIMER;
      end
      RX_XFER: begin
        bus.timer_active = 1'b1;
        bus.scl_sel      = TIMER;
        bus.sda_sel      = TIMER;
        bus.direction    = RX;
        bus.should_nack  = (remaining == RW'(1));
      end
      LOAD_DATA: begin
        bus.scl_sel    = LOW;
        bus.tx_ready   = bus.tx_valid;
        bus.load_shift = bus.tx_valid;
        bus.load_byte  = bus.tx_data;
      end
      RX_PUSH, GAP: bus.scl_sel = LOW;
      STOP_LOW: begin
        bus.scl_sel = LOW;
        bus.sda_sel = LOW;
      end
      STOP_SETUP: bus.sda_sel = LOW;
      default: ;
    endcase
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk, negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      addr         <= '0;
      rd           <= 1'b0;
      remaining    <= '0;
      bus.nack_err <= 1'b0;
      bus.arb_lost <= 1'b0;
      bus.done     <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.rx_valid <= 1'b0;
      if (in_xfer && bus.abort) begin
        bus.arb_lost <= 1'b1;
        bus.done     <= 1'b1;
        state        <= IDLE;
      end else begin
        case (state)
          IDLE: if (bus.start_txn) begin
            addr         <= bus.slave_addr;
            rd           <= bus.rw;
            remaining    <= (int'(bus.byte_count) > MAX_BYTES) ? RW'(MAX_BYTES)
                                                               : RW'(bus.byte_count);
            bus.nack_err <= 1'b0;
            bus.arb_lost <= 1'b0;
            state        <= BUS_WAIT;
          end
          BUS_WAIT:   if (tick) state <= START_HOLD;
          START_HOLD: if (tick) state <= LOAD_ADDR;
          LOAD_ADDR:  state <= ADDR_XFER;
          ADDR_XFER: if (bus.byte_complete) begin
            if (bus.ack) begin
              bus.nack_err <= 1'b1;
              state        <= STOP_LOW;
            end else if (remaining == '0) state <= STOP_LOW;
            else if (rd)                  state <= GAP;
            else                          state <= LOAD_DATA;
          end
          LOAD_DATA: if (bus.tx_valid) state <= TX_XFER;
          TX_XFER: if (bus.byte_complete) begin
            if (bus.ack) begin
              bus.nack_err <= 1'b1;
              state        <= STOP_LOW;
            end else begin
              if (remaining != '0) remaining <= remaining - RW'(1);
              state <= (remaining <= RW'(1)) ? STOP_LOW : LOAD_DATA;
            end
          end
          RX_XFER: if (bus.byte_complete) begin
            bus.rx_valid <= 1'b1;
            bus.rx_data  <= bus.rx_byte;
            state        <= RX_PUSH;
          end
          RX_PUSH: begin
            if (remaining != '0) remaining <= remaining - RW'(1);
            state <= (remaining <= RW'(1)) ? STOP_LOW : GAP;
          end
          GAP:        state <= RX_XFER;
          STOP_LOW:   if (tick) state <= STOP_SETUP;
          STOP_SETUP: if (tick) state <= STOP_HOLD;
          STOP_HOLD: if (tick) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Directed bench for the I2C transaction sequencer with a bit-timer model
// and scoreboard queues for loaded and received bytes.
module tb_i2c_master_sequencer;
  import i2c_master_sequencer_pkg::*;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  i2c_master_sequencer_if bus();

  i2c_master_sequencer #(.MAX_BYTES(32)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus.master)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_load[$];
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_vals[$];
  logic       ack_q[$];

  int tcnt, byte_idx, rx_cnt, rx_total, abort_idx, tx_hold, n_txr, n_done, n_rxv;
  bit abort_arm, abort_pend, abort_chk, stop_seen, stall_chk;
  LineSel prev_scl, prev_sda;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive model inputs just after the edge, observe at the negedge.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.start_txn = 1'b0;
    abort_chk  = abort_pend;
    abort_pend = 1'b0;
    stall_chk  = 1'b0;
    if (tx_hold > 0 && byte_idx > 0) begin
      bus.tx_valid = 1'b0;
      tx_hold--;
      stall_chk = 1'b1;
    end else begin
      bus.tx_valid = (tx_q.size() > 0);
      bus.tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
    bus.byte_complete = 1'b0;
    bus.ack           = 1'b0;
    bus.abort         = 1'b0;
    if (!n_rst || !bus.timer_active) tcnt = 0;
    else begin
      tcnt++;
      if (abort_arm && byte_idx == abort_idx && tcnt == 3) begin
        bus.abort  = 1'b1;
        abort_arm  = 1'b0;
        abort_pend = 1'b1;
      end else if (tcnt == 6) begin
        bus.byte_complete = 1'b1;
        bus.ack = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
        if (bus.direction == RX) begin
          chk("should_nack", bus.should_nack, (rx_cnt == rx_total - 1));
          if (rx_cnt < rx_vals.size()) bus.rx_byte = rx_vals[rx_cnt];
          rx_cnt++;
        end
        byte_idx++;
      end
    end
    @(negedge clk);
    if (bus.load_shift) begin
      if (exp_load.size() == 0) chk("load_byte_unexpected", {24'h0, bus.load_byte}, 32'h100);
      else                      chk("load_byte", bus.load_byte, exp_load.pop_front());
    end
    if (bus.tx_ready) begin
      n_txr++;
      if (tx_q.size() > 0) void'(tx_q.pop_front());
    end
    if (bus.rx_valid) begin
      n_rxv++;
      if (exp_rx.size() == 0) chk("rx_data_unexpected", {24'h0, bus.rx_data}, 32'h100);
      else                    chk("rx_data", bus.rx_data, exp_rx.pop_front());
    end
    if (bus.done) n_done++;
    if (stall_chk) chk("scl_stretch", bus.scl_sel, LOW);
    if (abort_chk) begin
      chk("abort_scl_rel", bus.scl_sel, RELEASE);
      chk("abort_sda_rel", bus.sda_sel, RELEASE);
      chk("abort_arb_lost", bus.arb_lost, 1);
      chk("abort_done", bus.done, 1);
    end
    if (prev_scl == LOW && prev_sda == LOW && bus.scl_sel == RELEASE && bus.sda_sel == LOW)
      stop_seen = 1'b1;
    prev_scl = bus.scl_sel;
    prev_sda = bus.sda_sel;
  endtask

  task automatic begin_txn(input logic [6:0] a, input logic r, input int n);
    byte_idx  = 0;
    rx_cnt    = 0;
    n_txr     = 0;
    n_done    = 0;
    n_rxv     = 0;
    stop_seen = 1'b0;
    exp_load.push_back({a, r});
    bus.slave_addr = a;
    bus.rw         = r;
    bus.byte_count = 6'(n);
    bus.start_txn  = 1'b1;
    tick();
    chk("busy_rise", bus.busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (n_done == 0 && k < 3000) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, (n_done != 0), 1);
    repeat (4) tick();
    chk({tag, "_done_once"}, n_done, 1);
    chk({tag, "_busy_fall"}, bus.busy, 0);
  endtask

  task automatic flush();
    exp_load.delete();
    exp_rx.delete();
    tx_q.delete();
    rx_vals.delete();
    ack_q.delete();
    abort_arm = 1'b0;
    tx_hold   = 0;
  endtask

  initial begin
    bus.clock_div = 32'd4;
    bus.start_txn = 1'b0;
    bus.slave_addr = '0;
    bus.rw = 1'b0;
    bus.byte_count = '0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    bus.rx_byte = '0;
    bus.SDA_sync = 1'b1;
    bus.SCL_sync = 1'b1;
    bus.byte_complete = 1'b0;
    bus.ack = 1'b0;
    bus.abort = 1'b0;
    tcnt = 0; byte_idx = 0; rx_cnt = 0; rx_total = 0; abort_idx = 0;
    tx_hold = 0; n_txr = 0; n_done = 0; n_rxv = 0;
    abort_arm = 0; abort_pend = 0; abort_chk = 0; stop_seen = 0; stall_chk = 0;
    prev_scl = RELEASE; prev_sda = RELEASE;

    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timer_active", bus.timer_active, 0);
    chk("rst_scl_sel", bus.scl_sel, RELEASE);
    chk("rst_sda_sel", bus.sda_sel, RELEASE);
    chk("rst_direction", bus.direction, TX);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_strobes", {bus.done, bus.rx_valid, bus.tx_ready, bus.load_shift}, 0);
    chk("rst_flags", {bus.nack_err, bus.arb_lost}, 0);
    n_rst = 1'b1;
    tick();

    // Write 0x50, two bytes, all ACK
    tx_q = '{8'hA5, 8'h3C};
    begin_txn(7'h50, 1'b0, 2);
    exp_load.push_back(8'hA5);
    exp_load.push_back(8'h3C);
    wait_done("wr");
    chk("wr_tx_ready_cnt", n_txr, 2);
    chk("wr_flags", {bus.nack_err, bus.arb_lost}, 0);
    chk("wr_stop", stop_seen, 1);
    chk("wr_load_left", exp_load.size(), 0);
    flush();

    // Read 0x50, three bytes
    rx_vals = '{8'h5A, 8'hC3, 8'h7E};
    exp_rx  = '{8'h5A, 8'hC3, 8'h7E};
    rx_total = 3;
    begin_txn(7'h50, 1'b1, 3);
    wait_done("rd");
    chk("rd_rx_valid_cnt", n_rxv, 3);
    chk("rd_load_left", exp_load.size(), 0);
    chk("rd_stop", stop_seen, 1);
    chk("rd_nack_err", bus.nack_err, 0);
    flush();

    // Address NACK
    ack_q.push_back(1'b1);
    tx_q = '{8'h11};
    begin_txn(7'h50, 1'b0, 1);
    wait_done("anack");
    chk("anack_nack_err", bus.nack_err, 1);
    chk("anack_stop", stop_seen, 1);
    chk("anack_tx_ready_cnt", n_txr, 0);
    flush();

    // Arbitration loss during the first data byte
    tx_q = '{8'hA5, 8'h3C};
    abort_arm = 1'b1;
    abort_idx = 1;
    begin_txn(7'h50, 1'b0, 2);
    exp_load.push_back(8'hA5);
    wait_done("abort");
    chk("abort_no_stop", stop_seen, 0);
    chk("abort_tx_ready_cnt", n_txr, 1);
    chk("abort_sticky", bus.arb_lost, 1);
    chk("abort_load_left", exp_load.size(), 0);
    flush();

    // Bus busy (SDA low) for 20 cycles, then a stalled TX byte
    bus.SDA_sync = 1'b0;
    tx_q = '{8'hC3};
    tx_hold = 10;
    begin_txn(7'h2A, 1'b0, 1);
    exp_load.push_back(8'hC3);
    chk("arb_lost_cleared", bus.arb_lost, 0);
    for (int i = 0; i < 19; i++) begin
      tick();
      chk("bus_wait_sda", bus.sda_sel, RELEASE);
    end
    bus.SDA_sync = 1'b1;
    begin
      int k = 0;
      while (bus.sda_sel != LOW && k < 50) begin
        tick();
        k++;
      end
      chk("start_delay", k, 4);
    end
    wait_done("stall");
    chk("stall_tx_ready_cnt", n_txr, 1);
    chk("stall_load_left", exp_load.size(), 0);
    chk("stall_stop", stop_seen, 1);
    flush();

    // Reset in the middle of a read
    rx_vals = '{8'h11, 8'h22, 8'h33};
    exp_rx  = '{8'h11, 8'h22, 8'h33};
    rx_total = 3;
    begin_txn(7'h50, 1'b1, 3);
    begin
      int k = 0;
      while (n_rxv == 0 && k < 500) begin
        tick();
        k++;
      end
      chk("mid_rx_reached", (n_rxv != 0), 1);
    end
    repeat (3) tick();
    n_rst = 1'b0;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_scl_sel", bus.scl_sel, RELEASE);
    chk("mrst_sda_sel", bus.sda_sel, RELEASE);
    chk("mrst_timer_active", bus.timer_active, 0);
    chk("mrst_rx", {bus.rx_valid, bus.rx_data}, 0);
    chk("mrst_direction", bus.direction, TX);
    chk("mrst_should_nack", bus.should_nack, 0);
    repeat (2) tick();
    n_rst = 1'b1;
    flush();
    tick();

    tx_q = '{8'h3C};
    begin_txn(7'h50, 1'b0, 1);
    exp_load.push_back(8'h3C);
    wait_done("post_rst");
    chk("post_rst_tx_ready_cnt", n_txr, 1);
    chk("post_rst_stop", stop_seen, 1);
    chk("post_rst_flags", {bus.nack_err, bus.arb_lost}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
